// File: rtl/vigna_prefetch_pkg.sv
// Shared types and constants for the vigna prefetch unit.
// Holds the core reset address used as the default fetch start and the
// layout of one queued instruction entry.
package vigna_prefetch_pkg;

  // Default first fetch address of the vigna core.
  localparam logic [31:0] VIGNA_CORE_RESET_ADDR = 32'h0000_0000;

  // One queue entry carries the instruction address and the fetched word.
  localparam int unsigned ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/vigna_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, WIDTH x DEPTH.
// The head entry is read asynchronously so the consumer sees it in the same
// cycle the read pointer moves; depth is small, so this maps to distributed
// RAM. Clear has priority over push and pop; pop on empty is ignored.
module vigna_sync_fifo
  import vigna_prefetch_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vigna_prefetch.sv
// Instruction prefetch unit for the vigna core.
// Keeps up to DEPTH {pc, data} entries queued ahead of decode, issues
// back-to-back bus requests and flushes on redirect, discarding a response
// that was already in flight. Optional macro VIGNA_PREFETCH_BYPASS_EN adds a
// same-cycle path from the bus response to the core when the queue is empty.
module vigna_prefetch
  import vigna_prefetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = VIGNA_CORE_RESET_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   i_valid,
  input  logic                   i_ready,
  output logic [31:0]            i_addr,
  input  logic [31:0]            i_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         r_valid;
  logic [31:0]  r_fetch_pc;
  logic         r_drop;
  logic [31:0]  r_pend_pc;

  logic         w_hs;
  logic         w_accept;
  logic         w_bypass;
  logic         w_push;
  logic         w_fifo_pop;
  logic         w_empty;
  logic         w_full;
  logic [CW-1:0] w_count;
  logic [CW:0]  w_count_next;
  logic         w_valid_next;
  logic [31:0]  w_redirect_pc;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  assign w_redirect_pc = align_word(redirect_pc);
  assign w_hs          = r_valid && i_ready;
  // A response is kept only if it is not stale and no flush is happening.
  assign w_accept      = w_hs && !r_drop && !redirect_valid;

`ifdef VIGNA_PREFETCH_BYPASS_EN
  assign w_bypass = w_empty && w_accept;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word consumed this cycle never enters the queue.
  assign w_push     = w_accept && !(w_bypass && inst_ready) && (!w_full || w_fifo_pop);
  assign w_fifo_pop = inst_ready && !w_empty;
  assign w_wdata    = '{pc: r_fetch_pc, data: i_rdata};

  vigna_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_fifo_pop),
    .clear (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Occupancy after this cycle decides whether another request may start.
  always_comb begin
    w_count_next = '0;
    if (!redirect_valid) begin
      w_count_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_fifo_pop);
    end
    w_valid_next = (r_valid && !i_ready) || (w_count_next < (CW+1)'(DEPTH));
  end

  // Request, fetch address and stale-response tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_fetch_pc <= RESET_ADDR;
      r_drop     <= 1'b0;
      r_pend_pc  <= RESET_ADDR;
    end else begin
      r_valid <= w_valid_next;
      if (w_hs) begin
        r_drop <= 1'b0;
        if (redirect_valid)  r_fetch_pc <= w_redirect_pc;
        else if (r_drop)     r_fetch_pc <= r_pend_pc;
        else                 r_fetch_pc <= r_fetch_pc + 32'd4;
      end else if (redirect_valid) begin
        // An outstanding request must finish at its old address; remember
        // where to go afterwards and discard what it returns.
        if (r_valid) begin
          r_drop    <= 1'b1;
          r_pend_pc <= w_redirect_pc;
        end else begin
          r_fetch_pc <= w_redirect_pc;
        end
      end
    end
  end

  // Core-side head presentation; zeros when nothing is valid.
  always_comb begin
    inst_valid = !w_empty;
    inst_data  = w_empty ? 32'd0 : w_head.data;
    inst_pc    = w_empty ? 32'd0 : w_head.pc;
    if (w_bypass) begin
      inst_valid = 1'b1;
      inst_data  = i_rdata;
      inst_pc    = r_fetch_pc;
    end
  end

  assign i_valid = r_valid;
  assign i_addr  = r_fetch_pc;
  assign level   = w_count;

endmodule
